max_pool_ctrl: RTL and testbench

Frame-level sequencer for the shared 4-lane max-pool unit. It streams 48-bit feature words in raster order and performs 2x2 stride-2 pooling in two passes through the single unit:
- a horizontal pass over adjacent column pairs, with even-row results parked in an internal line buffer;
- a vertical pass over the stored and current-row results on odd rows.

It also drives the unit in pass-through mode when pooling is disabled. It sits between the expand-layer output FIFO and the next-layer input.

---
 rtl/max_pool_ctrl.sv | 172 +++++++++++++++++
 tb/tb_max_pool_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/max_pool_ctrl.sv
// Frame sequencer for the shared 4-lane max-pool unit: 2x2/stride-2 pooling as an
// H pass (column pairs, even rows parked in a line buffer) plus a V pass on odd rows.
module max_pool_ctrl #(
  parameter int DATA_W   = 48,
  parameter int MAX_COLS = 256,
  parameter int DIM_W    = 9
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [DIM_W-1:0]  cfg_width_i,
  input  logic [DIM_W-1:0]  cfg_height_i,
  input  logic              cfg_pool_en_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [DATA_W-1:0] mp_data_1_o,
  output logic [DATA_W-1:0] mp_data_2_o,
  output logic              mp_max_en_o,
  input  logic [DATA_W-1:0] mp_data_max_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_valid_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              cfg_err_o
);

  localparam int AW     = $clog2(MAX_COLS/2);
  localparam int STAGES = 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;
  typedef enum logic [1:0] {T_H, T_V, T_B} tag_typ_t;
  typedef struct packed {
    tag_typ_t        typ;
    logic            row_odd;
    logic [AW-1:0]   addr;
  } tag_t;

  state_t             state_q, state_d;
  logic [DIM_W-1:0]   w_q, h_q, col_q, row_q;
  logic               pool_q;
  logic [DATA_W-1:0]  hold_q;
  logic [DATA_W-1:0]  linebuf [MAX_COLS/2];

  // Stage 0 rides with the mp_* issue registers; stage STAGES lines up with mp_data_max_i.
  logic [STAGES:0]        vld_pipe;
  tag_t [STAGES:0]        tag_pipe;

  logic cfg_bad, start_ok, start_err;
  logic xfer, last_xfer, col_last;
  logic h_odd_ret, h_even_ret;

  always_comb begin
    cfg_bad = (cfg_width_i == '0) || (cfg_height_i == '0);
    if (cfg_pool_en_i)
      cfg_bad = cfg_bad || cfg_width_i[0] || cfg_height_i[0] ||
                ({1'b0, cfg_width_i} > (DIM_W+1)'(MAX_COLS));
  end

  assign h_odd_ret  = vld_pipe[STAGES] && (tag_pipe[STAGES].typ == T_H) &&  tag_pipe[STAGES].row_odd;
  assign h_even_ret = vld_pipe[STAGES] && (tag_pipe[STAGES].typ == T_H) && !tag_pipe[STAGES].row_odd;

  assign col_last  = (col_q == w_q - DIM_W'(1));
  assign xfer      = in_valid_i && in_ready_o;
  assign last_xfer = xfer && col_last && (row_q == h_q - DIM_W'(1));

  always_comb begin
    state_d     = state_q;
    start_ok    = 1'b0;
    start_err   = 1'b0;
    in_ready_o  = 1'b0;
    busy_o      = (state_q != S_IDLE);
    done_o      = 1'b0;
    out_valid_o = vld_pipe[STAGES] && (tag_pipe[STAGES].typ != T_H);
    out_data_o  = out_valid_o ? mp_data_max_i : '0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          start_ok  = !cfg_bad;
          start_err = cfg_bad;
          if (!cfg_bad) state_d = S_RUN;
        end
      end
      S_RUN: begin
        // An odd-row H result owns the issue slot for its V op this cycle.
        in_ready_o = !h_odd_ret;
        if (last_xfer) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (vld_pipe == '0) begin
          done_o  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      w_q         <= '0;
      h_q         <= '0;
      pool_q      <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      hold_q      <= '0;
      cfg_err_o   <= 1'b0;
      mp_data_1_o <= '0;
      mp_data_2_o <= '0;
      mp_max_en_o <= 1'b0;
      vld_pipe    <= '0;
      tag_pipe    <= '0;
    end else begin
      state_q   <= state_d;
      cfg_err_o <= start_err;

      if (start_ok) begin
        w_q    <= cfg_width_i;
        h_q    <= cfg_height_i;
        pool_q <= cfg_pool_en_i;
        col_q  <= '0;
        row_q  <= '0;
      end else if (xfer) begin
        if (col_last) begin
          col_q <= '0;
          row_q <= row_q + DIM_W'(1);
        end else begin
          col_q <= col_q + DIM_W'(1);
        end
      end

      vld_pipe <= {vld_pipe[STAGES-1:0], 1'b0};
      for (int i = 1; i <= STAGES; i++) tag_pipe[i] <= tag_pipe[i-1];
      mp_max_en_o <= 1'b0;

      if (h_odd_ret) begin
        mp_data_1_o          <= linebuf[tag_pipe[STAGES].addr];
        mp_data_2_o          <= mp_data_max_i;
        mp_max_en_o          <= 1'b1;
        vld_pipe[0]          <= 1'b1;
        tag_pipe[0].typ      <= T_V;
        tag_pipe[0].row_odd  <= 1'b1;
        tag_pipe[0].addr     <= tag_pipe[STAGES].addr;
      end else if (xfer) begin
        if (!pool_q) begin
          mp_data_1_o          <= in_data_i;
          vld_pipe[0]          <= 1'b1;
          tag_pipe[0].typ      <= T_B;
          tag_pipe[0].row_odd  <= row_q[0];
          tag_pipe[0].addr     <= '0;
        end else if (!col_q[0]) begin
          hold_q <= in_data_i;
        end else begin
          mp_data_1_o          <= hold_q;
          mp_data_2_o          <= in_data_i;
          mp_max_en_o          <= 1'b1;
          vld_pipe[0]          <= 1'b1;
          tag_pipe[0].typ      <= T_H;
          tag_pipe[0].row_odd  <= row_q[0];
          tag_pipe[0].addr     <= col_q[AW:1];
        end
      end
    end
  end

  // Line buffer contents are don't-care after reset.
  always_ff @(posedge clk_i) begin
    if (h_even_ret) linebuf[tag_pipe[STAGES].addr] <= mp_data_max_i;
  end

endmodule

// File: tb/tb_max_pool_ctrl.sv
// Bench for max_pool_ctrl: behavioural 2-cycle max unit, directed frames, and a
// scoreboard queue checked by a monitor whenever out_valid_o fires.
module tb_max_pool_ctrl;
  localparam int DATA_W = 48;
  localparam int DIM_W  = 9;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              start_i = 1'b0;
  logic [DIM_W-1:0]  cfg_width_i = '0;
  logic [DIM_W-1:0]  cfg_height_i = '0;
  logic              cfg_pool_en_i = 1'b0;
  logic [DATA_W-1:0] in_data_i = '0;
  logic              in_valid_i = 1'b0;
  logic              in_ready_o;
  logic [DATA_W-1:0] mp_data_1_o, mp_data_2_o, mp_data_max_i, out_data_o;
  logic              mp_max_en_o, out_valid_o, busy_o, done_o, cfg_err_o;

  max_pool_ctrl #(.DATA_W(DATA_W), .MAX_COLS(256), .DIM_W(DIM_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .cfg_width_i(cfg_width_i), .cfg_height_i(cfg_height_i), .cfg_pool_en_i(cfg_pool_en_i),
    .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .mp_data_1_o(mp_data_1_o), .mp_data_2_o(mp_data_2_o), .mp_max_en_o(mp_max_en_o),
    .mp_data_max_i(mp_data_max_i), .out_data_o(out_data_o), .out_valid_o(out_valid_o),
    .busy_o(busy_o), .done_o(done_o), .cfg_err_o(cfg_err_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [47:0] rep(input int v);
    logic [11:0] l;
    l = v[11:0];
    return {l, l, l, l};
  endfunction

  function automatic logic [47:0] lane_max(input logic [47:0] a, input logic [47:0] b);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      r[12*i +: 12] = {1'b0, (a[12*i +: 11] > b[12*i +: 11]) ? a[12*i +: 11] : b[12*i +: 11]};
    return r;
  endfunction

  // Shared max unit: result valid 2 cycles after the issue is visible.
  logic [47:0] mu_s1 = '0, mu_s2 = '0;
  always @(posedge clk_i) begin
    mu_s1 <= mp_max_en_o ? lane_max(mp_data_1_o, mp_data_2_o) : mp_data_1_o;
    mu_s2 <= mu_s1;
  end
  assign mp_data_max_i = mu_s2;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct { logic [47:0] d; int c; } exp_t;
  exp_t sb[$];
  exp_t e_m;

  int tests = 0, fails = 0;
  int n_out = 0, last_out_cyc = 0, done_cnt = 0, done_cyc = 0, err_cnt = 0;
  int st_tot = 0, st_r0 = 0;
  logic [47:0] stim [64];
  logic [47:0] expv [16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk_i) begin
    if (out_valid_o) begin
      n_out++;
      last_out_cyc = cyc;
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL out_unexpected: got %h, expected no output (cycle %0d)", out_data_o, cyc);
      end else begin
        e_m = sb.pop_front();
        chk("out_data", 64'(out_data_o), 64'(e_m.d));
        chk("out_cycle", 64'(cyc), 64'(e_m.c));
      end
    end
    if (done_o) begin done_cnt++; done_cyc = cyc; end
    if (cfg_err_o) err_cnt++;
  end

  task automatic start_cfg(input int w, input int h, input bit pool);
    @(negedge clk_i);
    start_i = 1'b1; cfg_width_i = DIM_W'(w); cfg_height_i = DIM_W'(h); cfg_pool_en_i = pool;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  // Drives n words from stim[] with valid held high; pushes the expected result
  // on each transfer that completes an output.
  task automatic drive(input int n, input int w, input bit pool);
    int k, g, p;
    k = 0; g = 0; p = 0; st_tot = 0; st_r0 = 0;
    while (k < n && g < 2000) begin
      in_valid_i = 1'b1;
      in_data_i  = stim[k];
      if (in_ready_o) begin
        if (!pool) sb.push_back('{stim[k], cyc + 3});
        else if (((k / w) % 2 == 1) && ((k % w) % 2 == 1)) begin
          sb.push_back('{expv[p], cyc + 6});
          p++;
        end
        k++;
      end else begin
        st_tot++;
        if (k < w) st_r0++;
      end
      g++;
      @(negedge clk_i);
    end
    in_valid_i = 1'b0;
    chk("xfer_count", 64'(k), 64'(n));
  endtask

  task automatic finish_frame(input string nm, input int nexp);
    int g, d0;
    g = 0; d0 = done_cnt;
    while (done_cnt == d0 && g < 60) begin @(negedge clk_i); g++; end
    chk({nm, "_done_seen"}, 64'(done_cnt - d0), 64'd1);
    chk({nm, "_done_lat"}, 64'(done_cyc), 64'(last_out_cyc + 1));
    @(negedge clk_i);
    chk({nm, "_busy_clr"}, 64'(busy_o), 64'd0);
    chk({nm, "_n_out"}, 64'(n_out), 64'(nexp));
    chk({nm, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  task automatic load_s1();
    stim[0] = rep(5); stim[1] = rep(9); stim[2] = rep(3); stim[3] = rep(1);
    stim[4] = rep(7); stim[5] = rep(2); stim[6] = rep(8); stim[7] = rep(8);
    expv[0] = 48'h009009009009; expv[1] = 48'h008008008008;
  endtask

  task automatic run_s1(input string nm);
    load_s1();
    n_out = 0;
    start_cfg(4, 2, 1);
    chk({nm, "_busy_set"}, 64'(busy_o), 64'd1);
    drive(8, 4, 1);
    chk({nm, "_stalls"}, 64'(st_tot), 64'd0);
    finish_frame(nm, 2);
  endtask

  initial begin
    repeat (2) @(negedge clk_i);
    chk("rst_ctrl", 64'({busy_o, in_ready_o, out_valid_o, done_o, cfg_err_o, mp_max_en_o}), 64'd0);
    chk("rst_mp1", 64'(mp_data_1_o), 64'd0);
    chk("rst_mp2", 64'(mp_data_2_o), 64'd0);
    chk("rst_out", 64'(out_data_o), 64'd0);
    rst_i = 1'b0;

    // Illegal configs: odd width, then too-wide frame.
    begin
      int e0;
      e0 = err_cnt;
      start_cfg(3, 2, 1);
      repeat (4) begin
        chk("illegal_idle", 64'({busy_o, in_ready_o, mp_max_en_o, out_valid_o}), 64'd0);
        @(negedge clk_i);
      end
      chk("illegal_mp1", 64'(mp_data_1_o), 64'd0);
      chk("illegal_err_odd", 64'(err_cnt - e0), 64'd1);
      start_cfg(258, 2, 1);
      repeat (3) @(negedge clk_i);
      chk("illegal_err_wide", 64'(err_cnt - e0), 64'd2);
      chk("illegal_wide_busy", 64'(busy_o), 64'd0);
    end

    run_s1("pool4x2");

    // W=8 frame: lane-distinct words, bit 11 masking, odd-row stalls.
    for (int i = 0; i < 8; i++) stim[i] = rep(10 * (i + 1));
    stim[0]  = 48'hFFF00A00A00A;
    stim[8]  = rep(15);  stim[9]  = rep(5);  stim[10] = rep(35); stim[11] = rep(25);
    stim[12] = rep(45);  stim[13] = rep(55); stim[14] = 48'h0640007FF001; stim[15] = rep(0);
    expv[0] = 48'h7FF014014014; expv[1] = rep(40); expv[2] = rep(60); expv[3] = 48'h0640507FF050;
    n_out = 0;
    start_cfg(8, 2, 1);
    drive(16, 8, 1);
    chk("pool8_stalls", 64'(st_tot), 64'd2);
    chk("pool8_row0_stalls", 64'(st_r0), 64'd0);
    finish_frame("pool8x2", 4);

    // Bypass, full 48 bits.
    stim[0] = 48'h800000000001; stim[1] = 48'h123456789ABC;
    stim[2] = 48'hFFFFFFFFFFFF; stim[3] = 48'h000000000000;
    n_out = 0;
    start_cfg(2, 2, 0);
    drive(4, 2, 0);
    chk("byp_stalls", 64'(st_tot), 64'd0);
    finish_frame("byp2x2", 4);

    // Reset after 3 words of a 4x4 pooled frame.
    begin
      int d0;
      for (int i = 0; i < 16; i++) stim[i] = rep(i + 1);
      n_out = 0;
      start_cfg(4, 4, 1);
      drive(3, 4, 1);
      d0 = done_cnt;
      rst_i = 1'b1;
      @(negedge clk_i);
      chk("mrst_ctrl", 64'({busy_o, in_ready_o, out_valid_o, done_o, cfg_err_o, mp_max_en_o}), 64'd0);
      chk("mrst_mp1", 64'(mp_data_1_o), 64'd0);
      chk("mrst_out", 64'(out_data_o), 64'd0);
      rst_i = 1'b0;
      repeat (10) @(negedge clk_i);
      chk("mrst_no_done", 64'(done_cnt - d0), 64'd0);
      chk("mrst_no_out", 64'(n_out), 64'd0);
    end
    run_s1("pool4x2_after_rst");

    // start_i while busy with a different cfg must be ignored.
    begin
      int e0;
      e0 = err_cnt;
      load_s1();
      n_out = 0;
      start_cfg(4, 2, 1);
      fork
        drive(8, 4, 1);
        begin
          repeat (3) @(negedge clk_i);
          start_i = 1'b1; cfg_width_i = 9'd2; cfg_height_i = 9'd2; cfg_pool_en_i = 1'b0;
          @(negedge clk_i);
          start_i = 1'b0;
        end
      join
      finish_frame("busy_start", 2);
      chk("busy_start_no_err", 64'(err_cnt - e0), 64'd0);
      repeat (6) @(negedge clk_i);
      chk("busy_start_idle", 64'({busy_o, out_valid_o}), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete by time %0t", $time);
    $fatal(1);
  end

endmodule
